// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - fixed-width pulse generator with guaranteed low gap and pending-request replay
module pulse_generator #(
    parameter int   HIGH_CYCLES = 4,
    parameter int   LOW_CYCLES  = 4,
    parameter int   PEND_WIDTH  = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic                  CLK_I,
    input  logic                  RST_SYNC_I,
    input  logic                  TRIG_I,
    input  logic                  CLR_OVF_I,
    output logic                  SIG_O,
    output logic                  SIG_START_O,
    output logic                  SIG_END_O,
    output logic                  BUSY_O,
    output logic [PEND_WIDTH-1:0] PEND_O,
    output logic                  OVF_O
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int CMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0]         HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0]         LOW_LOAD  = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0]         CNT_ONE   = 1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE  = 1;
    localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    logic                  sig_q, sig_d;
    logic                  start_q, start_d;
    logic                  end_q, end_d;

    logic last_cnt;
    logic start;
    logic consume;
    logic accept;

    always_comb begin
        last_cnt = (cnt_q == '0);
        start    = ((state_q == S_IDLE) && TRIG_I) ||
                   ((state_q == S_GAP) && last_cnt && ((pend_q != '0) || TRIG_I));
        consume  = start && (pend_q != '0);
        // With nothing queued, a starting pulse absorbs the trigger itself.
        accept   = TRIG_I && !(start && (pend_q == '0));

        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q & ~CLR_OVF_I;
        start_d = start;
        end_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            S_HIGH: begin
                if (last_cnt) begin
                    state_d = S_GAP;
                    cnt_d   = LOW_LOAD;
                    end_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (last_cnt) begin
                    state_d = start ? S_HIGH : S_IDLE;
                    cnt_d   = HIGH_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (consume && !accept) begin
            pend_d = pend_q - PEND_ONE;
        end else if (accept && !consume) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end

        sig_d = (state_d == S_HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_SYNC_I) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            sig_q   <= IDLE_LEVEL;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            sig_q   <= sig_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign SIG_O       = sig_q;
    assign SIG_START_O = start_q;
    assign SIG_END_O   = end_q;
    assign BUSY_O      = (state_q != S_IDLE);
    assign PEND_O      = pend_q;
    assign OVF_O       = ovf_q;

endmodule

// File: tb/tb_pulse_generator.sv
// tb/tb_pulse_generator.sv - randomized and directed bench for pulse_generator against a timeline model
module tb_pulse_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, trig, clr;
    logic sig0, st0, en0, busy0, ovf0;
    logic sig1, st1, en1, busy1, ovf1;
    logic [1:0] pend0, pend1;
    logic [6:0] dv0, dv1;

    pulse_generator #(.HIGH_CYCLES(3), .LOW_CYCLES(2), .PEND_WIDTH(2), .IDLE_LEVEL(1'b0)) u_dut0 (
        .CLK_I(clk), .RST_SYNC_I(rst), .TRIG_I(trig), .CLR_OVF_I(clr),
        .SIG_O(sig0), .SIG_START_O(st0), .SIG_END_O(en0), .BUSY_O(busy0),
        .PEND_O(pend0), .OVF_O(ovf0));

    pulse_generator #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .PEND_WIDTH(2), .IDLE_LEVEL(1'b1)) u_dut1 (
        .CLK_I(clk), .RST_SYNC_I(rst), .TRIG_I(trig), .CLR_OVF_I(clr),
        .SIG_O(sig1), .SIG_START_O(st1), .SIG_END_O(en1), .BUSY_O(busy1),
        .PEND_O(pend1), .OVF_O(ovf1));

    assign dv0 = {sig0, st0, en0, busy0, pend0, ovf0};
    assign dv1 = {sig1, st1, en1, busy1, pend1, ovf1};

    // Model tracks each pulse by the absolute cycle its active phase begins.
    int t = 0;
    int s[2]    = '{-1000, -1000};
    int pend[2] = '{0, 0};
    bit ovf[2]  = '{1'b0, 1'b0};
    int HC[2]   = '{3, 1};
    int LC[2]   = '{2, 1};
    bit IL[2]   = '{1'b0, 1'b1};
    localparam int PMAX = 3;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_step(input int k, input logic tr, input logic cl, input logic rs);
        int  last_gap;
        bit  start, consume, accept, drop;
        if (rs) begin
            s[k] = -1000; pend[k] = 0; ovf[k] = 1'b0;
            return;
        end
        last_gap = s[k] + HC[k] + LC[k] - 1;
        start    = ((t > last_gap) && tr) || ((t == last_gap) && (pend[k] > 0 || tr));
        consume  = start && pend[k] > 0;
        accept   = tr && !(start && pend[k] == 0);
        drop     = accept && !consume && pend[k] == PMAX;
        if (start) s[k] = t + 1;
        if (!drop) pend[k] = pend[k] - int'(consume) + int'(accept);
        if (cl) ovf[k] = 1'b0;
        if (drop) ovf[k] = 1'b1;
    endtask

    function automatic logic [6:0] mdl_vec(input int k);
        logic hi, bz;
        hi = (t >= s[k]) && (t < s[k] + HC[k]);
        bz = (t >= s[k]) && (t <= s[k] + HC[k] + LC[k] - 1);
        return {hi ^ IL[k], t == s[k], t == s[k] + HC[k], bz, 2'(pend[k]), ovf[k]};
    endfunction

    task automatic tick(input logic tr, input logic cl, input logic rs);
        trig = tr; clr = cl; rst = rs;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, tr, cl, rs);
        t++;
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
            n_bad++; $display("FAIL reset_model dut0=%b exp0=%b dut1=%b exp1=%b", dv0, mdl_vec(0), dv1, mdl_vec(1));
        end
        n_cmp++;
        if (dv0 !== 7'b0000000) begin n_bad++; $display("FAIL reset_dut0 got=%b exp=0000000", dv0); end
        n_cmp++;
        if (dv1 !== 7'b1000000) begin n_bad++; $display("FAIL reset_dut1 got=%b exp=1000000", dv1); end
    endtask

    task automatic test_single();
        logic [6:0] e0, e1;
        for (int c = 1; c <= 8; c++) begin
            tick(c == 1, 1'b0, 1'b0);
            n_cmp++;
            if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
                n_bad++; $display("FAIL single_model c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, mdl_vec(0), dv1, mdl_vec(1));
            end
            e0 = {c >= 1 && c <= 3, c == 1, c == 4, c >= 1 && c <= 5, 2'b00, 1'b0};
            e1 = {c != 1, c == 1, c == 2, c >= 1 && c <= 2, 2'b00, 1'b0};
            n_cmp++;
            if (dv0 !== e0 || dv1 !== e1) begin
                n_bad++; $display("FAIL single_directed c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, e0, dv1, e1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 1; c <= 12; c++) begin
            tick((c - 1) <= 1, 1'b0, 1'b0);
            n_cmp++;
            if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
                n_bad++; $display("FAIL b2b_model c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, mdl_vec(0), dv1, mdl_vec(1));
            end
            if (c == 2) begin
                n_cmp++;
                if (pend0 !== 2'd1) begin n_bad++; $display("FAIL b2b_pend got=%0d exp=1", pend0); end
            end
            if (c == 6) begin
                n_cmp++;
                if ({st0, sig0, pend0} !== 4'b1100) begin n_bad++; $display("FAIL b2b_second got=%b exp=1100", {st0, sig0, pend0}); end
            end
            if (c == 11) begin
                n_cmp++;
                if (busy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", busy0); end
            end
        end
    endtask

    task automatic test_last_gap();
        for (int c = 1; c <= 12; c++) begin
            tick((c - 1) == 0 || (c - 1) == 5, 1'b0, 1'b0);
            n_cmp++;
            if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
                n_bad++; $display("FAIL lastgap_model c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, mdl_vec(0), dv1, mdl_vec(1));
            end
            n_cmp++;
            if (pend0 !== 2'd0 || busy0 !== (c <= 10) || sig0 !== ((c >= 1 && c <= 3) || (c >= 6 && c <= 8))) begin
                n_bad++; $display("FAIL lastgap_directed c=%0d sig=%b busy=%b pend=%0d", c, sig0, busy0, pend0);
            end
        end
    endtask

    task automatic test_overflow();
        int starts = 0;
        for (int c = 1; c <= 30; c++) begin
            tick((c - 1) <= 4, 1'b0, 1'b0);
            starts += int'(st0);
            n_cmp++;
            if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
                n_bad++; $display("FAIL ovf_model c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, mdl_vec(0), dv1, mdl_vec(1));
            end
            if (c == 5) begin
                n_cmp++;
                if ({ovf0, pend0} !== 3'b111) begin n_bad++; $display("FAIL ovf_set got=%b exp=111", {ovf0, pend0}); end
            end
        end
        n_cmp++;
        if (starts !== 4) begin n_bad++; $display("FAIL ovf_pulse_count got=%0d exp=4", starts); end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", ovf0); end
        for (int c = 1; c <= 30; c++) begin
            tick((c - 1) <= 4, (c - 1) == 4, 1'b0);
            n_cmp++;
            if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
                n_bad++; $display("FAIL ovfclr_model c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, mdl_vec(0), dv1, mdl_vec(1));
            end
            if (c == 5) begin
                n_cmp++;
                if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got=%b exp=1", ovf0); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 1; c <= 3; c++) tick(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({sig0, pend0} !== 3'b110) begin n_bad++; $display("FAIL midrst_pre got=%b exp=110", {sig0, pend0}); end
        tick(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({sig0, pend0, busy0, en0} !== 5'b00000) begin
            n_bad++; $display("FAIL midrst_abort got=%b exp=00000", {sig0, pend0, busy0, en0});
        end
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (busy0 !== 1'b0) begin n_bad++; $display("FAIL midrst_trig_ignored got=%b exp=0", busy0); end
        for (int c = 1; c <= 8; c++) begin
            tick(c == 1, 1'b0, 1'b0);
            n_cmp++;
            if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
                n_bad++; $display("FAIL midrst_model c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, mdl_vec(0), dv1, mdl_vec(1));
            end
            if (c == 1) begin
                n_cmp++;
                if ({st0, sig0} !== 2'b11) begin n_bad++; $display("FAIL midrst_restart got=%b exp=11", {st0, sig0}); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
            n_cmp++;
            if (dv0 !== mdl_vec(0) || dv1 !== mdl_vec(1)) begin
                n_bad++; $display("FAIL random_model c=%0d dut0=%b exp0=%b dut1=%b exp1=%b", c, dv0, mdl_vec(0), dv1, mdl_vec(1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; clr = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_last_gap();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Counterpart to the edge detectors: turns single-cycle trigger strobes into clean, fixed-width pulses on a level signal. Each pulse has a guaranteed minimum low gap after it, so a downstream synchronizer and edge detector sees every pulse. Triggers that arrive while a pulse or gap is in progress are counted in a small pending counter and replayed back-to-back. Used wherever a block must emit edges toward an external or clock-crossing receiver.

## Interface
Parameters:
- HIGH_CYCLES, 4, active pulse width in clock cycles (≥1)
- LOW_CYCLES, 4, minimum inactive gap after each pulse in cycles (≥1)
- PEND_WIDTH, 2, pending-counter width; max pending = 2^PEND_WIDTH−1
- IDLE_LEVEL, 1'b0, inactive level of SIG_O; active level = ~IDLE_LEVEL

Ports:
- CLK_I  in  1  clock, all logic on rising edge
- RST_SYNC_I  in  1  reset, synchronous, active-high
- TRIG_I  in  1  pulse request; each high cycle is one request
- CLR_OVF_I  in  1  clears OVF_O
- SIG_O  out  1  generated signal, registered
- SIG_START_O  out  1  one-cycle strobe in first active cycle of SIG_O
- SIG_END_O  out  1  one-cycle strobe in first gap cycle (SIG_O back to idle)
- BUSY_O  out  1  high when state ≠ IDLE
- PEND_O  out  PEND_WIDTH  queued requests not yet started
- OVF_O  out  1  sticky, a request was dropped

## Operation
- FSM states: IDLE, HIGH, GAP; a down-counter times HIGH (HIGH_CYCLES) and GAP (LOW_CYCLES).
- SIG_O = ~IDLE_LEVEL in HIGH, IDLE_LEVEL in IDLE and GAP.
- Start condition: (IDLE & TRIG_I) or (last GAP cycle & (PEND_O≠0 | TRIG_I)); on start, next state HIGH.
- IDLE: TRIG_I → HIGH; else stay. PEND_O is always 0 in IDLE.
- HIGH: after HIGH_CYCLES cycles → GAP.
- GAP: after LOW_CYCLES cycles → HIGH if start condition, else IDLE.
- Pending update per cycle. Define consume = start & PEND_O≠0, and accept = TRIG_I not itself used by start.
  - start with PEND_O=0 consumes TRIG_I directly.
  - PEND_O' = PEND_O − consume + accept.
  - accept with PEND_O at max and no consume: request dropped, PEND_O holds, OVF_O ← 1.
- OVF_O stays high until CLR_OVF_I; set and clear in the same cycle → set wins.
- SIG_START_O high exactly in each first HIGH cycle.
- SIG_END_O high exactly in each first GAP cycle.
- Reset (any state, including mid-pulse or mid-gap):
  - next edge: state IDLE, SIG_O = IDLE_LEVEL, PEND_O=0, OVF_O=0, BUSY_O=0, strobes 0.
  - no SIG_END_O is produced for an aborted pulse.
  - TRIG_I during reset is ignored.

## Timing
- Latency: TRIG_I in IDLE at cycle n → SIG_O active at cycles n+1 … n+HIGH_CYCLES.
  - SIG_START_O at n+1.
  - SIG_END_O at n+HIGH_CYCLES+1.
  - BUSY_O high n+1 … n+HIGH_CYCLES+LOW_CYCLES.
- Queued pulses repeat with period HIGH_CYCLES+LOW_CYCLES, with no extra idle cycle between them.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- HIGH=3, LOW=2, IDLE_LEVEL=0; reset, then TRIG_I at cycle 0:
  - SIG_O=1 at cycles 1–3, START@1, END@4, BUSY 1–5, idle at cycle 6.
- TRIG_I at cycles 0 and 1:
  - PEND_O=1 at cycle 2.
  - second pulse at cycles 6–8, PEND_O=0 from cycle 6, BUSY low at cycle 11.
- TRIG_I in last GAP cycle (cycle 5) with PEND_O=0:
  - pulse at 6–8 with no IDLE cycle between pulses; PEND_O stays 0.
- PEND_WIDTH=2; TRIG_I at cycles 0–4:
  - PEND_O reaches 3 and the 5th request is dropped; OVF_O=1 from cycle 5.
  - exactly 4 pulses; CLR_OVF_I clears OVF_O the next cycle.
  - CLR_OVF_I coincident with an overflowing TRIG_I leaves OVF_O=1.
- Assert RST_SYNC_I at cycle 2 of a pulse with PEND_O=2:
  - next cycle SIG_O=0, PEND_O=0, BUSY_O=0, no SIG_END_O.
  - TRIG_I after release starts a normal pulse.
- IDLE_LEVEL=1, HIGH=1, LOW=1: single trigger → SIG_O low for exactly one cycle, strobes as above.
